retire_trace: RTL

Parametrised, synthesizable retire-trace capture buffer for the MIPS pipeline. It samples every retired instruction (PC, instruction word, ALU result) qualified by the execute-stage ce into a circular buffer of DEPTH entries. On a programmable trigger it records a programmable number of post-trigger samples, then freezes. Stored entries are read out oldest-first through a one-cycle-latency request port, which gives the pipeline a hardware trace in place of a simulation-only monitor.

---
 rtl/retire_trace_if.sv | 54 +++++
 rtl/retire_trace.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/retire_trace_if.sv
`default_nettype none
// ============================================================================
// Module      : retire_trace_if
// Description : Bundle of the retire-trace capture buffer's sample, control
//               and readout signals.
//               master : the pipeline / debug host driving samples and
//                        requests into the trace buffer
//               slave  : the trace buffer itself
// Ports       : t_i_* sample/trigger/request inputs to the buffer,
//               t_o_* status and read data outputs from the buffer
// Revision    : 1.0 - initial release
// ============================================================================
interface retire_trace_if #(
  parameter int PC_WIDTH = 32,
  parameter int IWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int DEPTH    = 8
);
  localparam int AW = $clog2(DEPTH);

  logic                t_i_valid;
  logic [PC_WIDTH-1:0] t_i_pc;
  logic [IWIDTH-1:0]   t_i_instr;
  logic [DWIDTH-1:0]   t_i_alu;
  logic                t_i_arm;
  logic [1:0]          t_i_trig_mode;
  logic [PC_WIDTH-1:0] t_i_trig_pc;
  logic [IWIDTH-1:0]   t_i_trig_instr;
  logic [AW:0]         t_i_post;
  logic                t_i_rd_req;
  logic [1:0]          t_o_state;
  logic [AW:0]         t_o_count;
  logic [AW-1:0]       t_o_trig_idx;
  logic                t_o_rd_valid;
  logic [PC_WIDTH-1:0] t_o_rd_pc;
  logic [IWIDTH-1:0]   t_o_rd_instr;
  logic [DWIDTH-1:0]   t_o_rd_alu;
  logic                t_o_rd_last;

  modport master (
    output t_i_valid, t_i_pc, t_i_instr, t_i_alu, t_i_arm, t_i_trig_mode,
           t_i_trig_pc, t_i_trig_instr, t_i_post, t_i_rd_req,
    input  t_o_state, t_o_count, t_o_trig_idx, t_o_rd_valid, t_o_rd_pc,
           t_o_rd_instr, t_o_rd_alu, t_o_rd_last
  );

  modport slave (
    input  t_i_valid, t_i_pc, t_i_instr, t_i_alu, t_i_arm, t_i_trig_mode,
           t_i_trig_pc, t_i_trig_instr, t_i_post, t_i_rd_req,
    output t_o_state, t_o_count, t_o_trig_idx, t_o_rd_valid, t_o_rd_pc,
           t_o_rd_instr, t_o_rd_alu, t_o_rd_last
  );
endinterface
`default_nettype wire

// File: rtl/retire_trace.sv
`default_nettype none
// ============================================================================
// Module      : retire_trace
// Description : Retire-trace capture buffer. Records (PC, instruction, ALU
//               result) of every valid retired instruction into a circular
//               buffer, stops a programmable number of samples after a
//               trigger, then serves the entries oldest-first.
// Ports       : t_clk  - clock, rising edge
//               t_rst  - asynchronous active-high reset
//               bus    - retire_trace_if.slave (samples, trigger setup,
//                        read request, status and read data)
// Revision    : 1.0 - initial release
// ============================================================================
module retire_trace #(
  parameter int PC_WIDTH = 32,
  parameter int IWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int DEPTH    = 8
) (
  input  wire logic      t_clk,
  input  wire logic      t_rst,
  retire_trace_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   C_FULL     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_MAX_POST = (AW+1)'(DEPTH-1);
  localparam logic [AW:0]   C_ONE_W    = (AW+1)'(1);
  localparam logic [AW-1:0] C_ONE      = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state, w_state_n;
  logic [AW-1:0] r_wptr, w_wptr_n;
  logic [AW-1:0] r_rptr, w_rptr_n;
  logic [AW-1:0] r_trig_idx, w_trig_idx_n;
  logic [AW-1:0] r_remain, w_remain_n;
  logic [AW-1:0] r_post_eff, w_post_eff_n;
  logic [AW:0]   r_count, w_count_n;
  logic          w_write, w_pop, w_trig_hit;
  logic [AW-1:0] w_post_clamp;

  logic                r_rd_valid, r_rd_last;
  logic [PC_WIDTH-1:0] r_rd_pc;
  logic [IWIDTH-1:0]   r_rd_instr;
  logic [DWIDTH-1:0]   r_rd_alu;

  logic [PC_WIDTH-1:0] r_mem_pc    [DEPTH];
  logic [IWIDTH-1:0]   r_mem_instr [DEPTH];
  logic [DWIDTH-1:0]   r_mem_alu   [DEPTH];

  assign w_trig_hit = bus.t_i_valid &&
                      ((bus.t_i_trig_mode == 2'b00) ||
                       (bus.t_i_trig_mode == 2'b01 && bus.t_i_pc    == bus.t_i_trig_pc) ||
                       (bus.t_i_trig_mode == 2'b10 && bus.t_i_instr == bus.t_i_trig_instr));

  // Clamp to DEPTH-1 so the trigger entry can never be overwritten.
  assign w_post_clamp = (bus.t_i_post > C_MAX_POST) ? C_MAX_POST[AW-1:0]
                                                    : bus.t_i_post[AW-1:0];

  always_comb begin
    w_state_n    = r_state;
    w_wptr_n     = r_wptr;
    w_rptr_n     = r_rptr;
    w_trig_idx_n = r_trig_idx;
    w_remain_n   = r_remain;
    w_post_eff_n = r_post_eff;
    w_count_n    = r_count;
    w_write      = 1'b0;
    w_pop        = 1'b0;

    if (bus.t_i_arm) begin
      // Arm overrides everything, including a same-cycle sample or read.
      w_state_n    = S_ARMED;
      w_wptr_n     = '0;
      w_count_n    = '0;
      w_trig_idx_n = '0;
      w_remain_n   = '0;
      w_post_eff_n = '0;
    end else begin
      case (r_state)
        S_ARMED, S_POST: begin
          if (bus.t_i_valid) begin
            w_write  = 1'b1;
            w_wptr_n = r_wptr + C_ONE;
            if (r_count != C_FULL)
              w_count_n = r_count + C_ONE_W;
            if (r_state == S_ARMED) begin
              if (w_trig_hit) begin
                w_post_eff_n = w_post_clamp;
                w_remain_n   = w_post_clamp;
                w_state_n    = (w_post_clamp == '0) ? S_DONE : S_POST;
              end
            end else begin
              w_remain_n = r_remain - C_ONE;
              if (r_remain == C_ONE)
                w_state_n = S_DONE;
            end
            // Mod-DEPTH arithmetic: a full count truncates to 0, which
            // yields the right index and makes the oldest entry == wptr.
            if (w_state_n == S_DONE) begin
              w_trig_idx_n = w_count_n[AW-1:0] - C_ONE - w_post_eff_n;
              w_rptr_n     = w_wptr_n - w_count_n[AW-1:0];
            end
          end
        end
        S_DONE: begin
          if (bus.t_i_rd_req && r_count != '0) begin
            w_pop     = 1'b1;
            w_rptr_n  = r_rptr + C_ONE;
            w_count_n = r_count - C_ONE_W;
            if (r_count == C_ONE_W)
              w_state_n = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge t_clk or posedge t_rst) begin
    if (t_rst) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_trig_idx <= '0;
      r_remain   <= '0;
      r_post_eff <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_pc    <= '0;
      r_rd_instr <= '0;
      r_rd_alu   <= '0;
    end else begin
      r_state    <= w_state_n;
      r_wptr     <= w_wptr_n;
      r_rptr     <= w_rptr_n;
      r_trig_idx <= w_trig_idx_n;
      r_remain   <= w_remain_n;
      r_post_eff <= w_post_eff_n;
      r_count    <= w_count_n;
      r_rd_valid <= w_pop;
      r_rd_last  <= w_pop && (r_count == C_ONE_W);
      if (w_pop) begin
        r_rd_pc    <= r_mem_pc[r_rptr];
        r_rd_instr <= r_mem_instr[r_rptr];
        r_rd_alu   <= r_mem_alu[r_rptr];
      end
    end
  end

  // Storage needs no reset: entries are only read back after being written.
  always_ff @(posedge t_clk) begin
    if (w_write) begin
      r_mem_pc[r_wptr]    <= bus.t_i_pc;
      r_mem_instr[r_wptr] <= bus.t_i_instr;
      r_mem_alu[r_wptr]   <= bus.t_i_alu;
    end
  end

  assign bus.t_o_state    = r_state;
  assign bus.t_o_count    = r_count;
  assign bus.t_o_trig_idx = r_trig_idx;
  assign bus.t_o_rd_valid = r_rd_valid;
  assign bus.t_o_rd_pc    = r_rd_pc;
  assign bus.t_o_rd_instr = r_rd_instr;
  assign bus.t_o_rd_alu   = r_rd_alu;
  assign bus.t_o_rd_last  = r_rd_last;
endmodule
`default_nettype wire
